cache_arbiter: RTL and testbench
================================

# cache_arbiter

Round-robin front end that shares the single `Cache` search port between up to four requesters (e.g. fetch, load/store, prefetch). It accepts one request at a time and owns the cache handshake: it holds the address, pulses `search_cache`, waits for `search_done`, then routes data, hit and error status back to the granting requester. It also keeps saturating hit/miss statistics.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `TIMEOUT_CYC`, 64: maximum number of WAIT cycles before the arbiter abandons a search.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester; held until accepted.
- `req_addr`  in  NUM_REQ×32  byte address per requester.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept strobe.
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `resp_data`  out  64  shared response data; valid only while a `resp_valid` bit is high.
- `resp_hit`  out  1  cache hit flag for the current response.
- `resp_err`  out  1  misaligned address or timeout.
- `search_cache`  out  1  one-cycle search pulse to the cache.
- `cache_address`  out  32  address to the cache; stable from ISSUE through RESP.
- `search_done`  in  1  cache completion flag; sampled only in WAIT.
- `hit`  in  1  cache hit, sampled together with `search_done`.
- `cache_data`  in  64  cache data, sampled together with `search_done`.
- `hit_count`, `miss_count`  out  16  saturating statistics counters.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, searching upward with wrap-around.
  - Assert that requester's `req_ready` for this cycle.
  - Latch its address into `cache_address` and its index into `gnt_id`.
  - Next state: ISSUE. If `req_addr[2:0]` is nonzero, go directly to RESP with the error flag set.
- **ISSUE:** `search_cache`=1 for exactly one cycle; clear the wait counter; next state WAIT.
- **WAIT:** increment the wait counter each cycle.
  - On `search_done`=1: capture `cache_data` and `hit`; next state RESP.
  - If the counter reaches TIMEOUT_CYC first: set the error flag, force data to 0 and hit to 0; next state RESP.
  - If `search_done` and the timeout occur in the same cycle, `search_done` wins.
- **RESP:** assert `resp_valid[gnt_id]` with the captured data, hit and error.
  - Set `rr_ptr` = (`gnt_id`+1) mod NUM_REQ.
  - Increment `hit_count` on a hit, or `miss_count` on a miss, but only when there is no error.
  - Next state: IDLE.
- Counters saturate at 0xFFFF and never wrap.
- `req_valid` bits that drop without ever being accepted are ignored; no request is remembered across cycles.
- Address fields used for checks and logging: tag [31:14], set [13:5], block [4:3], byte offset [2:0].

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - All of `req_ready`, `resp_valid`, `search_cache`, `resp_hit`, `resp_err` = 0.
  - `resp_data`=0, `cache_address`=0, both counters 0.
- Reset asserted mid-transaction aborts the transaction immediately; no response is issued. The cache shares the same reset.
- Cycle numbering for a normal access:
  - Accept at cycle T.
  - `search_cache` at T+1.
  - `search_done` is seen no earlier than T+2.
  - `resp_valid` one cycle after `search_done` is seen.
- Misaligned access: accept at T, `resp_valid` with `resp_err`=1 at T+1; the cache is never touched.
- Back-to-back requests: the next accept happens no earlier than the cycle after RESP.
- A `search_done` during IDLE, ISSUE or RESP is ignored.
- All outputs are registered except `req_ready`, which is a decode of IDLE plus the picker result.

## Structure
- `cache_pkg` holds:
  - `ADDR_W`=32 and `DATA_W`=64.
  - `TAG_W`=18, `SET_W`=9, `BLOCK_W`=2, `OFFSET_W`=3.
  - The `arb_state_t` enum.
- Sub-module `rr_picker`: combinational; inputs `req_valid` and `rr_ptr`; outputs a one-hot grant, the grant index and an `any` flag.
- Parent module: FSM, latches, wait counter and statistics.

## Test plan
- **Single request, hit:** requester 0, address 65688 (tag 4, set 4, block 3); cache returns done=1, hit=1, data=0x1234 three cycles after the pulse.
  - `resp_valid`=01, data=0x1234, hit=1, `hit_count`=1.
- **Contention:** requesters 0 and 1 both valid continuously for four transactions.
  - Grants alternate 0,1,0,1.
  - `cache_address` stays stable during each WAIT.
- **Misaligned:** requester 1, address 0x0000_0004.
  - `resp_valid`=10 and `resp_err`=1 at T+1.
  - `search_cache` never asserts; counters unchanged.
- **Timeout:** cache never raises `search_done`.
  - `resp_err`=1, `resp_data`=0 after exactly 64 WAIT cycles.
  - Next request is accepted normally.
- **Reset mid-WAIT:** pull `reset` low while in WAIT.
  - All outputs are 0 immediately.
  - After release, the first grant goes to requester 0.
- **Saturation:** preload or drive 65,536 misses.
  - `miss_count` holds at 0xFFFF.
  - `hit_count` is unaffected.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, address field layout, arbiter FSM state and
// response record for the cache arbiter slice.
//   ADDR_W / DATA_W   : cache address and data widths
//   TAG/SET/BLOCK/OFF : byte address split [31:14] [13:5] [4:3] [2:0]
//   arb_state_t       : IDLE -> ISSUE -> WAIT -> RESP (or IDLE -> RESP)
package cache_pkg;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int TAG_W    = 18;
  localparam int SET_W    = 9;
  localparam int BLOCK_W  = 2;
  localparam int OFFSET_W = 3;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [SET_W-1:0]    set;
    logic [BLOCK_W-1:0]  block;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              hit;
    logic              err;
  } resp_t;

  // Accesses must be 8-byte aligned; any nonzero byte offset is rejected.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    addr_fields_t f;
    f = addr;
    return |f.offset;
  endfunction

  // Statistics hold at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_valid : per-requester pending flags
//   rr_ptr    : highest-priority requester this cycle
//   gnt       : one-hot grant (zero when nothing is pending)
//   gnt_idx   : binary index of the grant
//   any       : at least one requester is pending
module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);
  // Walk offsets from farthest to nearest so the requester closest to
  // rr_ptr (in upward, wrapping order) is the last writer and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int k;
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req_valid[IDX_W'(k)]) begin
        gnt_idx = IDX_W'(k);
        any     = 1'b1;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single cache search port among NUM_REQ
// requesters, one transaction at a time, with round-robin fairness.
//   req_valid/req_addr/req_ready : request side, req_ready is a one-cycle accept
//   resp_valid/resp_data/hit/err : one-cycle response to the granted requester
//   search_cache/cache_address   : cache request (pulse + held address)
//   search_done/hit/cache_data   : cache completion, sampled only in WAIT
//   hit_count/miss_count         : saturating statistics (error-free responses)
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_W-1:0]               resp_data,
  output logic                            resp_hit,
  output logic                            resp_err,
  output logic                            search_cache,
  output logic [ADDR_W-1:0]               cache_address,
  input  logic                            search_done,
  input  logic                            hit,
  input  logic [DATA_W-1:0]               cache_data,
  output logic [STAT_W-1:0]               hit_count,
  output logic [STAT_W-1:0]               miss_count
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [NUM_REQ-1:0]       resp_valid_q, resp_valid_d;
  resp_t                    resp_q, resp_d;
  logic                     search_q, search_d;
  logic [STAT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0]        miss_cnt_q, miss_cnt_d;

  logic [NUM_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .any       (pick_any)
  );

  // The only unregistered output; gated by reset so nothing is accepted
  // (or even advertised) while the block is held in reset.
  assign req_ready = (state_q == IDLE && reset) ? pick_gnt : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_id_d     = gnt_id_q;
    addr_d       = addr_q;
    wait_d       = wait_q;
    resp_d       = resp_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    resp_valid_d = '0;
    search_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_id_d = pick_idx;
          addr_d   = req_addr[pick_idx];
          if (misaligned(req_addr[pick_idx])) begin
            // Rejected without touching the cache.
            resp_d       = '{data: '0, hit: 1'b0, err: 1'b1};
            resp_valid_d = pick_gnt;
            state_d      = RESP;
          end else begin
            search_d = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        // Completion is checked first so it wins a same-cycle timeout.
        if (search_done) begin
          resp_d       = '{data: cache_data, hit: hit, err: 1'b0};
          resp_valid_d = NUM_REQ'(1) << gnt_id_q;
          state_d      = RESP;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          // This is the TIMEOUT_CYC-th WAIT cycle with no completion.
          resp_d       = '{data: '0, hit: 1'b0, err: 1'b1};
          resp_valid_d = NUM_REQ'(1) << gnt_id_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
        if (!resp_q.err) begin
          if (resp_q.hit) hit_cnt_d  = sat_inc(hit_cnt_q);
          else            miss_cnt_d = sat_inc(miss_cnt_q);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_id_q     <= '0;
      addr_q       <= '0;
      wait_q       <= '0;
      resp_valid_q <= '0;
      resp_q       <= '0;
      search_q     <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      addr_q       <= addr_d;
      wait_q       <= wait_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      search_q     <= search_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_q.data;
  assign resp_hit      = resp_q.hit;
  assign resp_err      = resp_q.err;
  assign search_cache  = search_q;
  assign cache_address = addr_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter (NUM_REQ=2, TIMEOUT_CYC=64). Inputs are
// driven and outputs sampled at the falling clock edge.
module tb_cache_arbiter;
  localparam int NUM_REQ = 2;

  logic                       clock = 1'b0;
  logic                       reset = 1'b0;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0][31:0]   req_addr;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [63:0]                resp_data;
  logic                       resp_hit;
  logic                       resp_err;
  logic                       search_cache;
  logic [31:0]                cache_address;
  logic                       search_done;
  logic                       hit;
  logic [63:0]                cache_data;
  logic [15:0]                hit_count;
  logic [15:0]                miss_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cache_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_hit      (resp_hit),
    .resp_err      (resp_err),
    .search_cache  (search_cache),
    .cache_address (cache_address),
    .search_done   (search_done),
    .hit           (hit),
    .cache_data    (cache_data),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk_counts(input string tag, input logic [15:0] h, input logic [15:0] m);
    chk({tag, ".hits"},   64'(hit_count),  64'(h));
    chk({tag, ".misses"}, 64'(miss_count), 64'(m));
  endtask

  // One aligned transaction starting in an IDLE cycle; the cache answers
  // 'lat' cycles after the search pulse. Ends at the following IDLE cycle.
  task automatic txn(input logic ri, input logic [31:0] a, input int lat,
                     input logic h, input logic [63:0] d, input logic hold,
                     input string tag);
    logic [NUM_REQ-1:0] oh;
    oh = 2'b01 << ri;
    req_valid = req_valid | oh;
    req_addr[ri] = a;
    #1 chk({tag, ".ready"}, 64'(req_ready), 64'(oh));
    tick();
    if (!hold) req_valid = req_valid & ~oh;
    chk({tag, ".pulse"}, 64'(search_cache), 64'(1));
    chk({tag, ".addr"},  64'(cache_address), 64'(a));
    for (int i = 1; i <= lat; i++) begin
      tick();
      chk({tag, ".pulse_once"}, 64'(search_cache), 64'(0));
      chk({tag, ".addr_hold"},  64'(cache_address), 64'(a));
      chk({tag, ".no_resp"},    64'(resp_valid), 64'(0));
      if (i == lat) begin
        search_done = 1'b1;
        hit         = h;
        cache_data  = d;
      end
    end
    tick();
    search_done = 1'b0;
    hit         = 1'b0;
    cache_data  = '0;
    chk({tag, ".rvalid"}, 64'(resp_valid), 64'(oh));
    chk({tag, ".rdata"},  resp_data, d);
    chk({tag, ".rhit"},   64'(resp_hit), 64'(h));
    chk({tag, ".rerr"},   64'(resp_err), 64'(0));
    chk({tag, ".raddr"},  64'(cache_address), 64'(a));
    tick();
    chk({tag, ".rvalid_off"}, 64'(resp_valid), 64'(0));
  endtask

  initial begin
    int n;
    req_valid   = '0;
    req_addr    = '0;
    search_done = 1'b0;
    hit         = 1'b0;
    cache_data  = '0;

    // Reset state, with requests pending to show req_ready stays low.
    repeat (3) tick();
    req_valid = 2'b11;
    #1;
    chk("rst.ready",  64'(req_ready), 64'(0));
    chk("rst.rvalid", 64'(resp_valid), 64'(0));
    chk("rst.pulse",  64'(search_cache), 64'(0));
    chk("rst.rdata",  resp_data, 64'(0));
    chk("rst.rhit",   64'(resp_hit), 64'(0));
    chk("rst.rerr",   64'(resp_err), 64'(0));
    chk("rst.addr",   64'(cache_address), 64'(0));
    chk_counts("rst", 16'd0, 16'd0);
    req_valid = '0;
    reset = 1'b1;
    tick();

    // Stray completion while IDLE does nothing.
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    chk("idle_done.rvalid", 64'(resp_valid), 64'(0));
    chk("idle_done.pulse",  64'(search_cache), 64'(0));

    // Single hit: tag 4, set 4, block 3.
    txn(1'b0, 32'd65688, 3, 1'b1, 64'h1234, 1'b0, "hit1");
    chk_counts("hit1", 16'd1, 16'd0);

    // Misaligned from requester 1: response next cycle, no search.
    req_valid = 2'b10;
    req_addr[1] = 32'h0000_0004;
    #1 chk("mis.ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = '0;
    chk("mis.rvalid", 64'(resp_valid), 64'(2'b10));
    chk("mis.rerr",   64'(resp_err), 64'(1));
    chk("mis.pulse",  64'(search_cache), 64'(0));
    tick();
    chk("mis.rvalid_off", 64'(resp_valid), 64'(0));
    chk("mis.pulse2",     64'(search_cache), 64'(0));
    chk_counts("mis", 16'd1, 16'd0);

    // Contention: both held valid, grants alternate 0,1,0,1.
    req_valid = 2'b11;
    req_addr[0] = 32'h0000_2040;
    req_addr[1] = 32'h0001_0108;
    txn(1'b0, 32'h0000_2040, 1, 1'b1, 64'hA0A0_0000_0000_0001, 1'b1, "cont0");
    txn(1'b1, 32'h0001_0108, 2, 1'b0, 64'hB1B1_0000_0000_0002, 1'b1, "cont1");
    txn(1'b0, 32'h0000_3048, 1, 1'b1, 64'hC2C2_0000_0000_0003, 1'b1, "cont2");
    txn(1'b1, 32'h0004_0010, 5, 1'b0, 64'hD3D3_0000_0000_0004, 1'b1, "cont3");
    req_valid = '0;
    chk_counts("cont", 16'd3, 16'd2);

    // Timeout: cache never completes; junk on the data/hit lines is dropped.
    req_valid = 2'b01;
    req_addr[0] = 32'h0000_0040;
    #1 chk("to.ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    chk("to.pulse", 64'(search_cache), 64'(1));
    cache_data = 64'hDEAD_BEEF;
    hit = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (resp_valid == '0 && n < 100);
    chk("to.latency", 64'(n), 64'(65));
    chk("to.rvalid",  64'(resp_valid), 64'(2'b01));
    chk("to.rerr",    64'(resp_err), 64'(1));
    chk("to.rdata",   resp_data, 64'(0));
    chk("to.rhit",    64'(resp_hit), 64'(0));
    cache_data = '0;
    hit = 1'b0;
    tick();
    chk_counts("to", 16'd3, 16'd2);
    txn(1'b0, 32'h0000_0080, 2, 1'b0, 64'h55, 1'b0, "after_to");
    chk_counts("after_to", 16'd3, 16'd3);

    // Reset in WAIT while requester 1 is being served (rr_ptr is 1 here).
    req_valid = 2'b10;
    req_addr[1] = 32'h0000_0300;
    #1 chk("rmid.ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = '0;
    chk("rmid.pulse", 64'(search_cache), 64'(1));
    tick();
    req_valid = 2'b11;
    reset = 1'b0;
    #1;
    chk("rmid.ready0",  64'(req_ready), 64'(0));
    chk("rmid.rvalid",  64'(resp_valid), 64'(0));
    chk("rmid.pulse0",  64'(search_cache), 64'(0));
    chk("rmid.rdata",   resp_data, 64'(0));
    chk("rmid.rerr",    64'(resp_err), 64'(0));
    chk("rmid.addr",    64'(cache_address), 64'(0));
    chk_counts("rmid", 16'd0, 16'd0);
    tick();
    reset = 1'b1;
    txn(1'b0, 32'h0000_0500, 1, 1'b1, 64'hBEEF, 1'b0, "post_rst");
    req_valid = '0;
    chk_counts("post_rst", 16'd1, 16'd0);

    // Saturation: preload the miss counter just below full.
    force dut.miss_cnt_q = 16'hFFFE;
    tick();
    release dut.miss_cnt_q;
    #1 chk("sat.preload", 64'(miss_count), 64'(16'hFFFE));
    txn(1'b1, 32'h0000_1000, 1, 1'b0, 64'h1, 1'b0, "sat1");
    chk_counts("sat1", 16'd1, 16'hFFFF);
    txn(1'b0, 32'h0000_1008, 1, 1'b0, 64'h2, 1'b0, "sat2");
    chk_counts("sat2", 16'd1, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
